rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_pkg.sv | 12 +
 rtl/rom_arbiter_rr_arb2.sv | 30 +++
 rtl/rom_arbiter.sv | 114 +++++++++++
 tb/tb_rom_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the instruction ROM arbiter: FSM encoding and ROM size default.
package rom_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int ROM_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-input round-robin grant; favours the requester that was not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ID of the most recent winner; resets to 1 so requester 0 wins the first tie
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[1] && (!req[0] || !last))
                gnt = 2'b10;
            else if (req[0])
                gnt = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (|gnt)
            last <= gnt[1];
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one combinational instruction ROM between the core fetch port and the debug/loader port.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ROM_WORDS = ROM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req0_valid,
    input  logic [ADDR_W-1:0] i_req0_addr,
    output logic              o_req0_ready,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_data,
    output logic              o_rsp0_err,
    input  logic              i_rsp0_ready,
    input  logic              i_req1_valid,
    input  logic [ADDR_W-1:0] i_req1_addr,
    output logic              o_req1_ready,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_data,
    output logic              o_rsp1_err,
    input  logic              i_rsp1_ready,
    output logic              o_rom_ce,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_inst
);

    localparam logic [ADDR_W+1:0] ROM_BYTES = (ADDR_W+2)'(ROM_WORDS) << 2;

    state_t            state;
    logic              owner;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        gnt;
    logic              hs;
    logic              addr_err;
    logic              rsp_ready_sel;
    logic [ADDR_W-1:0] hs_addr;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state == IDLE && !rst),
        .req ({i_req1_valid, i_req0_valid}),
        .gnt (gnt)
    );

    // A grant is only issued to a valid requester, so a grant is the handshake
    assign hs            = |gnt;
    assign hs_addr       = gnt[1] ? i_req1_addr : i_req0_addr;
    assign addr_err      = (hs_addr[1:0] != 2'b00) || ({2'b00, hs_addr} >= ROM_BYTES);
    assign rsp_ready_sel = owner ? i_rsp1_ready : i_rsp0_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            o_rom_ce   <= 1'b0;
            o_rom_addr <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        owner <= gnt[1];
                        if (addr_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state      <= FETCH;
                            o_rom_ce   <= 1'b1;
                            o_rom_addr <= hs_addr;
                        end
                    end
                end
                FETCH: begin
                    state      <= RESP;
                    o_rom_ce   <= 1'b0;
                    o_rom_addr <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= 1'b0;
                    rsp_data   <= i_rom_inst;
                end
                RESP: begin
                    if (rsp_ready_sel) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_req0_ready = gnt[0];
    assign o_req1_ready = gnt[1];

    assign o_rsp0_valid = rsp_valid && !owner;
    assign o_rsp1_valid = rsp_valid && owner;
    assign o_rsp0_err   = o_rsp0_valid && rsp_err;
    assign o_rsp1_err   = o_rsp1_valid && rsp_err;
    assign o_rsp0_data  = o_rsp0_valid ? rsp_data : '0;
    assign o_rsp1_data  = o_rsp1_valid ? rsp_data : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table, hand sequences, then random traffic vs a transaction model.
module tb_rom_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req0_valid, i_req1_valid;
    logic [AW-1:0] i_req0_addr, i_req1_addr;
    logic          o_req0_ready, o_req1_ready;
    logic          o_rsp0_valid, o_rsp1_valid;
    logic [DW-1:0] o_rsp0_data, o_rsp1_data;
    logic          o_rsp0_err, o_rsp1_err;
    logic          i_rsp0_ready, i_rsp1_ready;
    logic          o_rom_ce;
    logic [AW-1:0] o_rom_addr;
    logic [DW-1:0] i_rom_inst;

    logic [DW-1:0] mem [RW];

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_WORDS(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req0_valid (i_req0_valid),
        .i_req0_addr  (i_req0_addr),
        .o_req0_ready (o_req0_ready),
        .o_rsp0_valid (o_rsp0_valid),
        .o_rsp0_data  (o_rsp0_data),
        .o_rsp0_err   (o_rsp0_err),
        .i_rsp0_ready (i_rsp0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_addr  (i_req1_addr),
        .o_req1_ready (o_req1_ready),
        .o_rsp1_valid (o_rsp1_valid),
        .o_rsp1_data  (o_rsp1_data),
        .o_rsp1_err   (o_rsp1_err),
        .i_rsp1_ready (i_rsp1_ready),
        .o_rom_ce     (o_rom_ce),
        .o_rom_addr   (o_rom_addr),
        .i_rom_inst   (i_rom_inst)
    );

    assign i_rom_inst = mem[o_rom_addr[11:2]];

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        v0;  logic [31:0] a0;
        logic        v1;  logic [31:0] a1;
        logic        r0;  logic        r1;
        logic        rd0; logic        rd1;
        logic        ce;  logic [31:0] ra;
        logic        sv0; logic        e0; logic [31:0] d0;
        logic        sv1; logic        e1; logic [31:0] d1;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_req0_valid = v.v0; i_req0_addr = v.a0;
        i_req1_valid = v.v1; i_req1_addr = v.a1;
        i_rsp0_ready = v.r0; i_rsp1_ready = v.r1;
    endtask

    task automatic check(input string nm, input vec_t v);
        chk({nm, ".rdy0"}, 32'(o_req0_ready), 32'(v.rd0));
        chk({nm, ".rdy1"}, 32'(o_req1_ready), 32'(v.rd1));
        chk({nm, ".ce"},   32'(o_rom_ce),     32'(v.ce));
        chk({nm, ".raddr"}, o_rom_addr,       v.ra);
        chk({nm, ".rv0"},  32'(o_rsp0_valid), 32'(v.sv0));
        chk({nm, ".rv1"},  32'(o_rsp1_valid), 32'(v.sv1));
        if (v.sv0) begin
            chk({nm, ".err0"},  32'(o_rsp0_err), 32'(v.e0));
            chk({nm, ".data0"}, o_rsp0_data,     v.d0);
        end
        if (v.sv1) begin
            chk({nm, ".err1"},  32'(o_rsp1_err), 32'(v.e1));
            chk({nm, ".data1"}, o_rsp1_data,     v.d1);
        end
    endtask

    // Entered and left just after a rising edge
    task automatic run_vec(input string nm, input vec_t v);
        drive(v);
        @(negedge clk);
        check(nm, v);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k = $urandom_range(0, 9);
        if (k < 6)      return 32'($urandom_range(0, RW-1)) << 2;
        else if (k < 8) return (32'($urandom_range(0, RW-1)) << 2) | 32'($urandom_range(1, 3));
        else if (k == 8) return 32'(RW*4) + (32'($urandom_range(0, 255)) << 2);
        else            return 32'hFFFF_FFFC;
    endfunction

    // Transaction model: one access in flight, timed from its handshake cycle
    int          mcyc, m_hs;
    bit          m_inflight, m_err, m_own, m_last;
    logic [31:0] m_addr;

    initial begin
        vec_t v;
        for (int i = 0; i < RW; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_00A0;
        mem[1] = 32'h0000_00B1;
        mem[4] = 32'h2001_0005;

        // Reset state, with both requesters asserting valid
        rst = 1'b1;
        v = '{1,32'h0,1,32'h4,1,1, 0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0};
        drive(v);
        @(posedge clk); #2;
        check("reset", v);
        @(posedge clk); #1;
        rst = 1'b0;

        //            v0 a0        v1 a1      r0 r1 rd0 rd1 ce ra          sv0 e0 d0             sv1 e1 d1
        tbl.push_back('{1,32'h0,   1,32'h4,   1,1,  1,0,  0,32'h0,       0,0,32'h0,          0,0,32'h0});
        tbl.push_back('{0,32'h0,   1,32'h4,   1,1,  0,0,  1,32'h0,       0,0,32'h0,          0,0,32'h0});
        tbl.push_back('{0,32'h0,   1,32'h4,   1,1,  0,0,  0,32'h0,       1,0,32'hA0,         0,0,32'h0});
        tbl.push_back('{1,32'h0,   1,32'h4,   1,1,  0,1,  0,32'h0,       0,0,32'h0,          0,0,32'h0});
        tbl.push_back('{1,32'h0,   0,32'h0,   1,1,  0,0,  1,32'h4,       0,0,32'h0,          0,0,32'h0});
        tbl.push_back('{1,32'h0,   0,32'h0,   1,1,  0,0,  0,32'h0,       0,0,32'h0,          1,0,32'hB1});
        tbl.push_back('{1,32'h0,   0,32'h0,   1,1,  1,0,  0,32'h0,       0,0,32'h0,          0,0,32'h0});
        tbl.push_back('{0,32'h0,   0,32'h0,   1,1,  0,0,  1,32'h0,       0,0,32'h0,          0,0,32'h0});
        tbl.push_back('{0,32'h0,   0,32'h0,   1,1,  0,0,  0,32'h0,       1,0,32'hA0,         0,0,32'h0});
        tbl.push_back('{1,32'h10,  0,32'h0,   1,1,  1,0,  0,32'h0,       0,0,32'h0,          0,0,32'h0});
        tbl.push_back('{0,32'h0,   1,32'h4,   1,1,  0,0,  1,32'h10,      0,0,32'h0,          0,0,32'h0});
        tbl.push_back('{0,32'h0,   0,32'h4,   1,1,  0,0,  0,32'h0,       1,0,32'h2001_0005,  0,0,32'h0});
        tbl.push_back('{0,32'h0,   0,32'h0,   1,1,  0,0,  0,32'h0,       0,0,32'h0,          0,0,32'h0});
        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Backpressure: response held 5 cycles, pending req1 must not be granted
        run_vec("bp_hs",    '{1,32'h10,0,32'h0,0,0, 1,0,0,32'h0,  0,0,32'h0, 0,0,32'h0});
        run_vec("bp_fetch", '{0,32'h0,1,32'h4,0,0,  0,0,1,32'h10, 0,0,32'h0, 0,0,32'h0});
        for (int i = 0; i < 5; i++)
            run_vec($sformatf("bp_hold%0d", i),
                    '{0,32'h0,1,32'h4,0,0, 0,0,0,32'h0, 1,0,32'h2001_0005, 0,0,32'h0});
        run_vec("bp_take",  '{0,32'h0,1,32'h4,1,0,  0,0,0,32'h0,  1,0,32'h2001_0005, 0,0,32'h0});
        run_vec("bp_req1",  '{0,32'h0,1,32'h4,1,0,  0,1,0,32'h0,  0,0,32'h0, 0,0,32'h0});
        run_vec("bp_f1",    '{0,32'h0,0,32'h0,1,0,  0,0,1,32'h4,  0,0,32'h0, 0,0,32'h0});
        run_vec("bp_r1",    '{0,32'h0,0,32'h0,1,1,  0,0,0,32'h0,  0,0,32'h0, 1,0,32'hB1});

        // Error responses: misaligned then first out-of-range byte address
        run_vec("err_mis_hs",  '{0,32'h0,1,32'h2,1,1,     0,1,0,32'h0, 0,0,32'h0, 0,0,32'h0});
        run_vec("err_mis_rsp", '{0,32'h0,0,32'h0,1,1,     0,0,0,32'h0, 0,0,32'h0, 1,1,32'h0});
        run_vec("err_oor_hs",  '{0,32'h0,1,32'(RW*4),1,1, 0,1,0,32'h0, 0,0,32'h0, 0,0,32'h0});
        run_vec("err_oor_rsp", '{0,32'h0,0,32'h0,1,1,     0,0,0,32'h0, 0,0,32'h0, 1,1,32'h0});
        run_vec("err_idle",    '{0,32'h0,0,32'h0,1,1,     0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0});

        // Reset pulse in the middle of a fetch
        run_vec("rst_hs", '{1,32'h10,0,32'h0,1,1, 1,0,0,32'h0, 0,0,32'h0, 0,0,32'h0});
        v = '{0,32'h0,0,32'h0,0,0, 0,0,1,32'h10, 0,0,32'h0, 0,0,32'h0};
        drive(v);
        @(negedge clk);
        check("rst_fetch", v);
        #1;
        rst = 1'b1;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        #1;
        v = '{1,32'h0,1,32'h0,0,0, 0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0};
        check("rst_async", v);
        @(posedge clk); #1;
        rst = 1'b0;
        v = '{0,32'h0,0,32'h0,1,1, 0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0};
        run_vec("rst_post0", v);
        run_vec("rst_post1", v);
        run_vec("rst_new_hs",  '{1,32'h10,1,32'h4,1,1, 1,0,0,32'h0,  0,0,32'h0, 0,0,32'h0});
        run_vec("rst_new_f",   '{0,32'h0,0,32'h0,1,1,  0,0,1,32'h10, 0,0,32'h0, 0,0,32'h0});
        run_vec("rst_new_rsp", '{0,32'h0,0,32'h0,1,1,  0,0,0,32'h0,  1,0,32'h2001_0005, 0,0,32'h0});

        // Random traffic against the transaction model
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mcyc = 0; m_hs = 0; m_inflight = 0; m_err = 0; m_own = 0; m_last = 1; m_addr = '0;
        for (int n = 0; n < 2000; n++) begin
            vec_t ev;
            bit   sv, g0, g1;
            ev = '{0,32'h0,0,32'h0,0,0, 0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0};
            ev.v0 = ($urandom_range(0, 9) < 7);
            ev.v1 = ($urandom_range(0, 9) < 5);
            ev.a0 = rand_addr();
            ev.a1 = rand_addr();
            ev.r0 = ($urandom_range(0, 9) < 6);
            ev.r1 = ($urandom_range(0, 9) < 6);
            drive(ev);

            g1 = !m_inflight && ev.v1 && (!ev.v0 || !m_last);
            g0 = !m_inflight && ev.v0 && !g1;
            sv = m_inflight && (mcyc >= m_hs + (m_err ? 1 : 2));
            ev.rd0 = g0;
            ev.rd1 = g1;
            ev.ce  = m_inflight && !m_err && (mcyc == m_hs + 1);
            ev.ra  = ev.ce ? m_addr : 32'h0;
            ev.sv0 = sv && !m_own;
            ev.sv1 = sv && m_own;
            ev.e0  = m_err;
            ev.e1  = m_err;
            ev.d0  = m_err ? 32'h0 : mem[m_addr[11:2]];
            ev.d1  = ev.d0;

            @(negedge clk);
            check($sformatf("rnd%0d", n), ev);

            if (g0 || g1) begin
                m_inflight = 1;
                m_hs   = mcyc;
                m_own  = g1;
                m_last = g1;
                m_addr = g1 ? ev.a1 : ev.a0;
                m_err  = (m_addr[1:0] != 2'b00) || (m_addr >= 32'(RW*4));
            end else if (sv && (m_own ? ev.r1 : ev.r0)) begin
                m_inflight = 0;
            end
            mcyc++;
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
